// File: rtl/cache_bus_pkg.sv
// Shared encodings for the cache-to-memory-bus arbiter: FSM states, owner ids, access sizes.
// Pure definitions; no logic.
package cache_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker, purely combinational (zero latency, no backpressure).
// On a tie the side that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ~last;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one SRAM-like bus between i-side and d-side, one transaction in flight at a time.
// addr_ok same cycle as the winning req, bus_req one cycle later; losers hold req until granted.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  inst_req,
  input  logic [1:0]            inst_size,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,

  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,

  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata,

  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                bus_wr_q, bus_wr_d;
  logic [1:0]          bus_size_q, bus_size_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;

  logic [1:0]          pick_req;
  logic                gnt_valid;
  logic                gnt_id;

  // Requests are masked while reset is held so no addr_ok can leak out combinationally.
  assign pick_req = rst ? {data_req, inst_req} : 2'b00;

  rr_pick2 u_pick (
    .req       (pick_req),
    .last      (last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d      = REQ;
          last_grant_d = gnt_id;
          owner_d      = gnt_id;
          if (gnt_id == OWNER_DATA) begin
            data_addr_ok = 1'b1;
            bus_wr_d     = data_wr;
            bus_size_d   = data_size;
            bus_addr_d   = data_addr;
            bus_wdata_d  = data_wdata;
            bus_wstrb_d  = data_wstrb;
          end else begin
            inst_addr_ok = 1'b1;
            bus_wr_d     = 1'b0;
            bus_size_d   = inst_size;
            bus_addr_d   = inst_addr;
            bus_wdata_d  = '0;
            bus_wstrb_d  = '0;
          end
        end
      end
      REQ: begin
        if (bus_addr_ok) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // Return to IDLE without granting: the next grant is evaluated in IDLE proper.
        if (bus_data_ok) begin
          state_d = IDLE;
          if (owner_q == OWNER_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = bus_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = bus_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWNER_INST;
      owner_q      <= OWNER_INST;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= 2'b00;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
    end
  end

  assign bus_req   = (state_q == REQ);
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: a scripted zero/multi-wait slave and a response scoreboard.
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   failed;

  cache_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    chk32(tag, {31'd0, obs}, {31'd0, expv});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // IDLE cycle with requests already driven: check who wins, record the expected response.
  task automatic grant(input logic own, input logic [31:0] rd);
    #3;
    chk1("grant_inst_addr_ok", inst_addr_ok, ~own);
    chk1("grant_data_addr_ok", data_addr_ok, own);
    chk1("grant_busy", busy, 1'b0);
    exp_q.push_back({own, rd});
    cyc();
  endtask

  task automatic idle_check(input string tag);
    #3;
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_addr_ok"}, inst_addr_ok | data_addr_ok, 1'b0);
    chk1({tag, "_data_ok"}, inst_data_ok | data_data_ok, 1'b0);
    cyc();
  endtask

  task automatic check_resp();
    exp_t e;
    if (inst_data_ok || data_data_ok) begin
      if (exp_q.size() == 0) begin
        chk32("resp_sb_size", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk1("resp_owner_data_ok", data_data_ok, e.owner);
        chk1("resp_other_data_ok", inst_data_ok, ~e.owner);
        chk32("resp_rdata", e.owner ? data_rdata : inst_rdata, e.rdata);
        chk32("resp_other_rdata", e.owner ? inst_rdata : data_rdata, 32'd0);
      end
    end else begin
      chk1("resp_seen", inst_data_ok | data_data_ok, 1'b1);
    end
  endtask

  // Entered at the first REQ cycle; the slave holds addr_ok low for aw cycles, then responds.
  task automatic serve(input int aw, input logic spur, input logic drop, input logic [31:0] rd,
                       input logic e_wr, input logic [1:0] e_size, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic [3:0] e_strb);
    for (int w = 0; w <= aw; w++) begin
      bus_addr_ok = (w == aw);
      bus_data_ok = spur;
      #3;
      chk1("req_bus_req", bus_req, 1'b1);
      chk1("req_busy", busy, 1'b1);
      chk32("req_bus_addr", bus_addr, e_addr);
      chk1("req_bus_wr", bus_wr, e_wr);
      chk32("req_bus_size", 32'(bus_size), 32'(e_size));
      chk32("req_bus_wdata", bus_wdata, e_wdata);
      chk32("req_bus_wstrb", 32'(bus_wstrb), 32'(e_strb));
      chk1("req_no_data_ok", inst_data_ok | data_data_ok, 1'b0);
      chk32("req_rdata_zero", inst_rdata | data_rdata, 32'd0);
      cyc();
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = rd;
    if (drop) inst_req = 1'b0;
    #3;
    chk1("resp_bus_req", bus_req, 1'b0);
    chk1("resp_no_addr_ok", inst_addr_ok | data_addr_ok, 1'b0);
    check_resp();
    cyc();
    bus_data_ok = 1'b0;
    bus_rdata   = 32'd0;
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    rst         = 1'b0;
    inst_req    = 1'b1;
    inst_size   = SIZE_WORD;
    inst_addr   = 32'h0;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = SIZE_WORD;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    data_wstrb  = 4'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;

    // Reset state, with requests asserted to confirm nothing is granted during reset.
    #3;
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_addr_ok", inst_addr_ok | data_addr_ok, 1'b0);
    chk1("rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    chk32("rst_bus_addr", bus_addr, 32'd0);
    chk1("rst_bus_wr", bus_wr, 1'b0);
    inst_req = 1'b0;
    data_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;

    // Single instruction read, zero-wait slave.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    grant(OWNER_INST, 32'h3C1D_BFC0);
    inst_req = 1'b0;
    serve(0, 1'b0, 1'b0, 32'h3C1D_BFC0, 1'b0, SIZE_WORD, 32'hBFC0_0000, 32'd0, 4'h0);
    idle_check("single_done");

    // First tie after reset goes to DATA, then the waiting INST side.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0010;
    data_req  = 1'b1;
    data_addr = 32'h8000_0010;
    grant(OWNER_DATA, 32'hA000_0001);
    data_req = 1'b0;
    serve(1, 1'b0, 1'b0, 32'hA000_0001, 1'b0, SIZE_WORD, 32'h8000_0010, 32'd0, 4'h0);
    grant(OWNER_INST, 32'hA000_0002);
    inst_req = 1'b0;
    serve(0, 1'b0, 1'b0, 32'hA000_0002, 1'b0, SIZE_WORD, 32'hBFC0_0010, 32'd0, 4'h0);

    // Sustained contention: grants alternate D,I,D,I,D,I.
    inst_req = 1'b1;
    data_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic own;
      own = (k % 2 == 0) ? OWNER_DATA : OWNER_INST;
      grant(own, 32'h0000_1000 + 32'(k));
      serve(0, 1'b0, 1'b0, 32'h0000_1000 + 32'(k), 1'b0, SIZE_WORD,
            own ? 32'h8000_0010 : 32'hBFC0_0010, 32'd0, 4'h0);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    idle_check("contention_done");

    // Halfword write, slave stalls addr_ok for 4 cycles.
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = SIZE_HALF;
    data_addr  = 32'h8000_1002;
    data_wdata = 32'h0000_BEEF;
    data_wstrb = 4'h3;
    grant(OWNER_DATA, 32'h55AA_55AA);
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wdata = 32'd0;
    data_wstrb = 4'h0;
    data_size  = SIZE_WORD;
    serve(4, 1'b0, 1'b0, 32'h55AA_55AA, 1'b1, SIZE_HALF, 32'h8000_1002, 32'h0000_BEEF, 4'h3);

    // Spurious bus_data_ok in IDLE and during REQ.
    bus_data_ok = 1'b1;
    idle_check("spur_idle");
    bus_data_ok = 1'b0;
    inst_req  = 1'b1;
    inst_size = SIZE_BYTE;
    inst_addr = 32'hBFC0_0021;
    grant(OWNER_INST, 32'h0000_0077);
    inst_req = 1'b0;
    serve(2, 1'b1, 1'b0, 32'h0000_0077, 1'b0, SIZE_BYTE, 32'hBFC0_0021, 32'd0, 4'h0);

    // inst_req dropped during RESP still completes.
    inst_req  = 1'b1;
    inst_size = SIZE_WORD;
    inst_addr = 32'hBFC0_0030;
    grant(OWNER_INST, 32'h0000_0088);
    serve(0, 1'b0, 1'b1, 32'h0000_0088, 1'b0, SIZE_WORD, 32'hBFC0_0030, 32'd0, 4'h0);
    idle_check("drop_done");

    // Reset while in RESP abandons the transaction.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0040;
    grant(OWNER_INST, 32'h0000_0099);
    inst_req    = 1'b0;
    bus_addr_ok = 1'b1;
    #3;
    chk1("mid_req_bus_req", bus_req, 1'b1);
    cyc();
    bus_addr_ok = 1'b0;
    #1;
    chk1("mid_resp_busy", busy, 1'b1);
    chk1("mid_resp_bus_req", bus_req, 1'b0);
    rst         = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h0000_0099;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_bus_req", bus_req, 1'b0);
    chk1("mid_rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    chk32("mid_rst_bus_addr", bus_addr, 32'd0);
    exp_q.delete();
    cyc();
    bus_data_ok = 1'b0;
    bus_rdata   = 32'd0;
    cyc();
    rst = 1'b1;

    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0050;
    grant(OWNER_INST, 32'h0000_00AB);
    inst_req = 1'b0;
    serve(0, 1'b0, 1'b0, 32'h0000_00AB, 1'b0, SIZE_WORD, 32'hBFC0_0050, 32'd0, 4'h0);
    idle_check("post_rst_done");

    chk32("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
